// File: rtl/crc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc_pkg: shared CRC helpers (bit-serial advance, stage sizing)             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package crc_pkg;

  localparam int c_MAX_W = 64;

  function automatic int stage_bits(input int word_len, input int big);
    return (big != 0) ? word_len : word_len / 2;
  endfunction

  function automatic int num_stages(input int len, input int word_len, input int big);
    return len / stage_bits(word_len, big);
  endfunction

  // MSB-first serial CRC update; constant nbits/width unroll to pure XOR logic.
  function automatic logic [c_MAX_W-1:0] crc_advance(
    input logic [c_MAX_W-1:0] crc,
    input logic [c_MAX_W-1:0] bits,
    input int                 nbits,
    input int                 width,
    input logic [c_MAX_W-1:0] poly
  );
    logic [c_MAX_W-1:0] r;
    logic [c_MAX_W-1:0] mask;
    logic               fb;
    mask = (width >= c_MAX_W) ? '1 : ((c_MAX_W'(1) << width) - c_MAX_W'(1));
    r    = crc & mask;
    for (int i = c_MAX_W - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = r[width-1] ^ bits[i];
        r  = ((r << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc_stage: advances the CRC by p_k bits and forwards the carried word      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module crc_stage
  import crc_pkg::*;
#(
  parameter int                   p_k            = 8,
  parameter int                   p_width        = 8,
  parameter logic [p_width-1:0]   p_polynom      = 8'h31,
  parameter int                   p_half         = 0,   // 0: whole word, 1: upper half, 2: lower half
  parameter int                   p_inp_data_len = 8
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [p_width-1:0]        i_crc,
  input  logic [p_inp_data_len-1:0] i_data,
  output logic [p_width-1:0]        o_crc,
  output logic [p_inp_data_len-1:0] o_data
);

  logic [p_k-1:0]            w_bits;
  logic [p_width-1:0]        w_next;
  logic [p_width-1:0]        r_crc;
  logic [p_inp_data_len-1:0] r_data;

  if (p_half == 1) begin : g_upper
    assign w_bits = i_data[p_inp_data_len-1 -: p_k];
  end else if (p_half == 2) begin : g_lower
    assign w_bits = i_data[p_k-1:0];
  end else begin : g_full
    assign w_bits = i_data;
  end

  assign w_next = p_width'(crc_advance(c_MAX_W'(i_crc), c_MAX_W'(w_bits), p_k, p_width,
                                       c_MAX_W'(p_polynom)));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_crc  <= '0;
      r_data <= '0;
    end else begin
      r_crc  <= w_next;
      r_data <= i_data;
    end
  end

  assign o_crc  = r_crc;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/crc_test.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc_test: fully pipelined CRC of a word repeated p_len/p_inp_data_len times|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module crc_test
  import crc_pkg::*;
#(
  parameter int                 p_len           = 128,
  parameter int                 p_width         = 8,
  parameter logic [p_width-1:0] p_polynom       = 8'h31,
  parameter int                 p_inp_data_len  = 8,
  parameter int                 p_FPGA_CELL_big = 1
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [p_inp_data_len-1:0] inp_data,
  output logic [p_width-1:0]        outp_data
);

  localparam int c_K = stage_bits(p_inp_data_len, p_FPGA_CELL_big);
  localparam int c_N = num_stages(p_len, p_inp_data_len, p_FPGA_CELL_big);

  if (((p_len % p_inp_data_len) != 0) || ((p_inp_data_len % 2) != 0)) begin : g_bad_params
    $error("crc_test: p_len must be a multiple of p_inp_data_len, which must be even");
  end

  logic [p_inp_data_len-1:0] r_data0;
  logic [p_width-1:0]        w_crc  [0:c_N];
  logic [p_inp_data_len-1:0] w_data [0:c_N];

  // Stage 0: the CRC starts at zero, so only the word needs a register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_data0 <= '0;
    end else begin
      r_data0 <= inp_data;
    end
  end

  assign w_crc[0]  = '0;
  assign w_data[0] = r_data0;

  for (genvar i = 1; i <= c_N; i++) begin : g_stage
    crc_stage #(
      .p_k            (c_K),
      .p_width        (p_width),
      .p_polynom      (p_polynom),
      .p_half         ((p_FPGA_CELL_big != 0) ? 0 : (((i % 2) == 1) ? 1 : 2)),
      .p_inp_data_len (p_inp_data_len)
    ) u_stage (
      .clk    (clk),
      .rstN   (rstN),
      .i_crc  (w_crc[i-1]),
      .i_data (w_data[i-1]),
      .o_crc  (w_crc[i]),
      .o_data (w_data[i])
    );
  end

  assign outp_data = w_crc[c_N];

endmodule
`default_nettype wire

// File: tb/tb_crc_test.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_crc_test: randomized self-checking bench with polynomial-division model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_crc_test;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] inp_data = 8'h00;
  logic [7:0] o_def, o_b0, o_p8, o_p16;
  logic [7:0] outs [4];

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;
  logic [7:0] hist [0:4095];

  // Four views: default, half-width stages, single-word and two-word messages.
  int    n_st   [4] = '{16, 32, 1, 2};
  int    n_cp   [4] = '{16, 16, 1, 2};
  string nm     [4] = '{"def", "big0", "len8", "len16"};

  always #5 clk = ~clk;

  crc_test dut_def (.clk(clk), .rstN(rstN), .inp_data(inp_data), .outp_data(o_def));
  crc_test #(.p_FPGA_CELL_big(0)) dut_b0 (.clk(clk), .rstN(rstN), .inp_data(inp_data), .outp_data(o_b0));
  crc_test #(.p_len(8))  dut_p8  (.clk(clk), .rstN(rstN), .inp_data(inp_data), .outp_data(o_p8));
  crc_test #(.p_len(16)) dut_p16 (.clk(clk), .rstN(rstN), .inp_data(inp_data), .outp_data(o_p16));

  assign outs[0] = o_def;
  assign outs[1] = o_b0;
  assign outs[2] = o_p8;
  assign outs[3] = o_p16;

  // Word captured at each edge; reset wipes everything still in flight.
  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 4096; i++) hist[i] <= 8'h00;
    end
    hist[ecount] <= rstN ? inp_data : 8'h00;
    ecount       <= ecount + 1;
  end

  // CRC as remainder of M(x)*x^8 divided by x^8+x^5+x^4+1 (long division).
  function automatic logic [7:0] crc_ref(input logic [7:0] w, input int copies);
    bit         q[$];
    logic [8:0] g;
    logic [7:0] r;
    g = 9'h131;
    for (int c = 0; c < copies; c++)
      for (int b = 7; b >= 0; b--) q.push_back(w[b]);
    for (int b = 0; b < 8; b++) q.push_back(1'b0);
    for (int i = 0; i < q.size() - 8; i++)
      if (q[i])
        for (int j = 0; j <= 8; j++) q[i+j] = q[i+j] ^ g[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = q[q.size()-8+j];
    return r;
  endfunction

  function automatic logic [7:0] exp_out(input int n, input int copies);
    int idx;
    idx = ecount - 1 - n;
    return (idx < 0) ? 8'h00 : crc_ref(hist[idx], copies);
  endfunction

  task automatic test_reset();
    rstN = 1'b0;
    repeat (10) begin
      @(negedge clk); inp_data = 8'($urandom);
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (outs[d] !== 8'h00) begin
          failures++;
          $display("FAIL reset_%s: got %h expected 00", nm[d], outs[d]);
        end
      end
    end
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] vin  [4] = '{8'h30, 8'hFF, 8'h00, 8'h01};
    logic [7:0] vexp [4] = '{8'hC5, 8'hAC, 8'h00, 8'h31};
    for (int v = 0; v < 4; v++) begin
      @(negedge clk); inp_data = vin[v];
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (o_p8 !== vexp[v]) begin
        failures++;
        $display("FAIL single_%h: got %h expected %h", vin[v], o_p8, vexp[v]);
      end
    end
  endtask

  task automatic test_two_copies();
    @(negedge clk); inp_data = 8'h30;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_p16 !== 8'h77) begin
      failures++;
      $display("FAIL two_copies: got %h expected 77", o_p16);
    end
  endtask

  task automatic test_constant();
    logic [7:0] ref16;
    ref16 = crc_ref(8'h30, 16);
    @(negedge clk); rstN = 1'b0; inp_data = 8'h30;
    #1;
    checks++;
    if (o_def !== 8'h00) begin
      failures++;
      $display("FAIL const_reset: got %h expected 00", o_def);
    end
    @(negedge clk); rstN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (o_def !== ((k >= 17) ? ref16 : 8'h00)) begin
        failures++;
        $display("FAIL const_def_edge%0d: got %h expected %h", k, o_def, (k >= 17) ? ref16 : 8'h00);
      end
      checks++;
      if (o_b0 !== ((k >= 33) ? ref16 : 8'h00)) begin
        failures++;
        $display("FAIL const_big0_edge%0d: got %h expected %h", k, o_b0, (k >= 33) ? ref16 : 8'h00);
      end
    end
  endtask

  task automatic test_stream(input int cycles);
    logic [7:0] e;
    repeat (cycles) begin
      @(negedge clk); inp_data = 8'($urandom);
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        e = exp_out(n_st[d], n_cp[d]);
        checks++;
        if (outs[d] !== e) begin
          failures++;
          $display("FAIL stream_%s@%0d: got %h expected %h", nm[d], ecount, outs[d], e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    test_stream(40);
    @(negedge clk); rstN = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (outs[d] !== 8'h00) begin
        failures++;
        $display("FAIL midreset_async_%s: got %h expected 00", nm[d], outs[d]);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (outs[d] !== 8'h00) begin
        failures++;
        $display("FAIL midreset_held_%s: got %h expected 00", nm[d], outs[d]);
      end
    end
    @(negedge clk); rstN = 1'b1;
    test_stream(60);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_two_copies();
    test_constant();
    test_stream(200);
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
